// File: rtl/cp15_sysctrl_unit.sv
`default_nettype none
// ============================================================================
// cp15_sysctrl_unit : parametrised CP15 system-control slave answering MRC/MCR
// Optional c15 cycle counter enabled by CP15_CYCLE_COUNTER_EN.   Rev 1.0
// ============================================================================
module cp15_sysctrl_unit #(
  parameter int          CP_NUM      = 15,
  parameter logic [31:0] ID_VALUE    = 32'h41007700,
  parameter int          NUM_CRN     = 4,
  parameter int          BUSY_CYCLES = 2,
  parameter logic [31:0] CTRL_WMASK  = 32'h0000000F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cp_req,
  input  logic [1:0]  cp_op,
  input  logic [3:0]  cp_num,
  input  logic [3:0]  cp_crn,
  input  logic [3:0]  cp_crm,
  input  logic [2:0]  cp_opcode1,
  input  logic [2:0]  cp_opcode2,
  input  logic [31:0] cp_wdata,
  output logic        cp_present,
  output logic        cp_ready,
  output logic        cp_exception,
  output logic [31:0] cp_rdata,
  output logic        cp_busy,
  output logic [31:0] ctrl_out
);

  localparam logic [3:0] CP_ID     = 4'(CP_NUM);
  localparam logic [3:0] BUSY_INIT = 4'(BUSY_CYCLES);
  localparam logic [4:0] CRN_LIMIT = 5'(NUM_CRN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [3:0]  busy_cnt, busy_cnt_d;
  logic [3:0]  crn_q;
  logic [31:0] wdata_q;
  logic        is_mcr_q, illegal_q;
  logic [31:0] ctrl_q, rdata_q;
  logic [31:0] scratch [16];

  logic        accept, crn_ok, legal_req, wr_en, load_rdata, sel_mrc;
  logic [3:0]  sel_crn;
  logic [31:0] read_val;

  assign cp_present = (cp_num == CP_ID);
  assign accept     = (state == IDLE) && cp_req && cp_present;

`ifdef CP15_CYCLE_COUNTER_EN
  assign crn_ok = ({1'b0, cp_crn} < CRN_LIMIT) || (cp_crn == 4'hF);
`else
  assign crn_ok = ({1'b0, cp_crn} < CRN_LIMIT);
`endif

  assign legal_req = cp_op[1] && (cp_opcode1 == 3'd0) && (cp_crm == 4'd0) &&
                     (cp_opcode2 == 3'd0) && crn_ok;

  always_comb begin
    state_d    = state;
    busy_cnt_d = busy_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal_req || (BUSY_INIT == 4'd0)) begin
            state_d = RESP;
          end else begin
            state_d    = BUSY;
            busy_cnt_d = BUSY_INIT;
          end
        end
      end
      BUSY: begin
        if (busy_cnt == 4'd1) state_d = RESP;
        else                  busy_cnt_d = busy_cnt - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_cnt <= '0;
    end else begin
      state    <= state_d;
      busy_cnt <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crn_q     <= '0;
      wdata_q   <= '0;
      is_mcr_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      crn_q     <= cp_crn;
      wdata_q   <= cp_wdata;
      is_mcr_q  <= ~cp_op[0];
      illegal_q <= ~legal_req;
    end
  end

  // With zero wait cycles RESP is entered on the accepting edge, so read live fields.
  assign sel_crn    = (state == IDLE) ? cp_crn : crn_q;
  assign sel_mrc    = (state == IDLE) ? (legal_req && (cp_op == 2'b11)) : (!illegal_q && !is_mcr_q);
  assign load_rdata = (state != RESP) && (state_d == RESP) && sel_mrc;
  assign wr_en      = (state == RESP) && !illegal_q && is_mcr_q;

`ifdef CP15_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n)                          cyc_cnt <= '0;
    else if (wr_en && (crn_q == 4'hF))   cyc_cnt <= wdata_q;
    else                                 cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  always_comb begin
    read_val = scratch[sel_crn];
    if (sel_crn == 4'd0)      read_val = ID_VALUE;
    else if (sel_crn == 4'd1) read_val = ctrl_q;
`ifdef CP15_CYCLE_COUNTER_EN
    else if (sel_crn == 4'hF) read_val = cyc_cnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          rdata_q <= '0;
    else if (load_rdata) rdata_q <= read_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                        ctrl_q <= '0;
    else if (wr_en && (crn_q == 4'd1)) ctrl_q <= (ctrl_q & ~CTRL_WMASK) | (wdata_q & CTRL_WMASK);
  end

  // Unimplemented slots stay at zero so the read mux can index all 16 entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (!rst_n || (i < 2) || (i >= NUM_CRN)) scratch[i] <= '0;
      else if (wr_en && (crn_q == 4'(i)))      scratch[i] <= wdata_q;
    end
  end

  assign cp_ready     = (state == RESP);
  assign cp_exception = (state == RESP) && illegal_q;
  assign cp_busy      = (state == BUSY);
  assign cp_rdata     = rdata_q;
  assign ctrl_out     = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_cp15_sysctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_cp15_sysctrl_unit : randomized self-checking bench with reference model.
// Rev 1.0
// ============================================================================
module tb_cp15_sysctrl_unit;

  localparam int          CP_NUM      = 15;
  localparam logic [31:0] ID_VALUE    = 32'h41007700;
  localparam int          NUM_CRN     = 4;
  localparam int          BUSY_CYCLES = 2;
  localparam logic [31:0] CTRL_WMASK  = 32'h0000000F;
`ifdef CP15_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [1:0] OP_CDP = 2'b00, OP_LDC = 2'b01, OP_MCR = 2'b10, OP_MRC = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cp_req = 1'b0;
  logic [1:0]  cp_op = '0;
  logic [3:0]  cp_num = '0, cp_crn = '0, cp_crm = '0;
  logic [2:0]  cp_opcode1 = '0, cp_opcode2 = '0;
  logic [31:0] cp_wdata = '0;
  logic        cp_present, cp_ready, cp_exception, cp_busy;
  logic [31:0] cp_rdata, ctrl_out;

  cp15_sysctrl_unit #(
    .CP_NUM(CP_NUM), .ID_VALUE(ID_VALUE), .NUM_CRN(NUM_CRN),
    .BUSY_CYCLES(BUSY_CYCLES), .CTRL_WMASK(CTRL_WMASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cp_req(cp_req), .cp_op(cp_op), .cp_num(cp_num),
    .cp_crn(cp_crn), .cp_crm(cp_crm), .cp_opcode1(cp_opcode1), .cp_opcode2(cp_opcode2),
    .cp_wdata(cp_wdata), .cp_present(cp_present), .cp_ready(cp_ready),
    .cp_exception(cp_exception), .cp_rdata(cp_rdata), .cp_busy(cp_busy), .ctrl_out(ctrl_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference architectural state
  logic [31:0] m_regs [16];
  logic [31:0] m_ctrl, m_rdata;
  logic [31:0] edges = '0;
  logic [31:0] cnt_base_edge = '0, cnt_base_val = '0;

  // Counter value held after edge k is base_val + (k - base_edge).
  always @(posedge clk) begin
    edges = edges + 32'd1;
    if (!rst_n) begin
      cnt_base_edge = edges;
      cnt_base_val  = '0;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_ctrl  = '0;
    m_rdata = '0;
  endtask

  function automatic bit model_legal(input logic [1:0] op, input logic [3:0] crn,
                                     input logic [3:0] crm, input logic [2:0] o1, input logic [2:0] o2);
    bit implemented = (int'(crn) < NUM_CRN) || (CNT_EN && crn == 4'hF);
    return (op == OP_MRC || op == OP_MCR) && o1 == 0 && crm == 0 && o2 == 0 && implemented;
  endfunction

  // Called at the negedge following the edge that entered RESP.
  function automatic logic [31:0] model_read(input logic [3:0] crn);
    if (crn == 0) return ID_VALUE;
    if (crn == 1) return m_ctrl;
    if (crn == 15 && CNT_EN) return cnt_base_val + (edges - 32'd1 - cnt_base_edge);
    return m_regs[crn];
  endfunction

  task automatic model_write(input logic [3:0] crn, input logic [31:0] wd);
    if (crn == 1)                  m_ctrl = (m_ctrl & ~CTRL_WMASK) | (wd & CTRL_WMASK);
    else if (crn == 15 && CNT_EN) begin
      cnt_base_val  = wd;
      cnt_base_edge = edges + 32'd1;
    end
    else if (crn >= 2)             m_regs[crn] = wd;
  endtask

  task automatic do_access(input logic [1:0] op, input logic [3:0] crn, input logic [3:0] crm,
                           input logic [2:0] o1, input logic [2:0] o2, input logic [31:0] wd);
    bit legal;
    bit got;
    int lat, nbusy;
    @(negedge clk);
    cp_req = 1'b1; cp_op = op; cp_num = 4'(CP_NUM); cp_crn = crn; cp_crm = crm;
    cp_opcode1 = o1; cp_opcode2 = o2; cp_wdata = wd;
    #1 check("present", {31'b0, cp_present}, 32'd1);
    legal = model_legal(op, crn, crm, o1, o2);
    got = 1'b0; lat = 0; nbusy = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      lat = c;
      if (cp_busy)  nbusy++;
      if (cp_ready) got = 1'b1;
    end
    check("ready_seen", {31'b0, got}, 32'd1);
    check("latency", lat, legal ? BUSY_CYCLES + 1 : 1);
    check("busy_cycles", nbusy, legal ? BUSY_CYCLES : 0);
    check("exception", {31'b0, cp_exception}, {31'b0, !legal});
    if (legal && op == OP_MRC) m_rdata = model_read(crn);
    check("rdata", cp_rdata, m_rdata);
    cp_req   = 1'b0;
    cp_wdata = $urandom;
    if (legal && op == OP_MCR) model_write(crn, wd);
    @(negedge clk);
    check("ready_pulse", {31'b0, cp_ready}, 32'd0);
    check("ctrl_out", ctrl_out, m_ctrl);
  endtask

  task automatic do_absent(input logic [3:0] num);
    int nready = 0;
    @(negedge clk);
    cp_req = 1'b1; cp_op = OP_MRC; cp_num = num; cp_crn = 4'd0; cp_crm = 4'd0;
    cp_opcode1 = 3'd0; cp_opcode2 = 3'd0;
    #1 check("absent_present", {31'b0, cp_present}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cp_ready) nready++;
    end
    check("absent_no_ready", nready, 0);
    cp_req = 1'b0;
  endtask

  task automatic reset_in_busy();
    int nready = 0;
    @(negedge clk);
    cp_req = 1'b1; cp_op = OP_MCR; cp_num = 4'(CP_NUM); cp_crn = 4'd2; cp_crm = 4'd0;
    cp_opcode1 = 3'd0; cp_opcode2 = 3'd0; cp_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    check("rst_mid_busy_pre", {31'b0, cp_busy}, 32'd1);
    rst_n  = 1'b0;
    cp_req = 1'b0;
    @(negedge clk);
    if (cp_ready) nready++;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (cp_ready) nready++;
    end
    check("rst_mid_no_ready", nready, 0);
    check("rst_mid_busy_post", {31'b0, cp_busy}, 32'd0);
    check("rst_mid_ctrl", ctrl_out, 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [3:0]  crn, crm;
    logic [2:0]  o1, o2;
    int          r;

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, cp_ready}, 32'd0);
    check("rst_exception", {31'b0, cp_exception}, 32'd0);
    check("rst_busy", {31'b0, cp_busy}, 32'd0);
    check("rst_rdata", cp_rdata, 32'd0);
    check("rst_ctrl", ctrl_out, 32'd0);
    rst_n = 1'b1;

    do_access(OP_MRC, 4'd0, 4'd0, 3'd0, 3'd0, 32'd0);
    do_access(OP_MCR, 4'd1, 4'd0, 3'd0, 3'd0, 32'hFFFFFFFF);
    do_access(OP_MRC, 4'd1, 4'd0, 3'd0, 3'd0, 32'd0);
    do_access(OP_MCR, 4'd0, 4'd0, 3'd0, 3'd0, 32'h12345678);
    do_access(OP_MRC, 4'd0, 4'd0, 3'd0, 3'd0, 32'd0);
    do_absent(4'd14);
    do_access(OP_CDP, 4'd1, 4'd0, 3'd0, 3'd0, 32'h0);
    do_access(OP_MRC, 4'd7, 4'd0, 3'd0, 3'd0, 32'd0);
    do_access(OP_MRC, 4'd1, 4'd0, 3'd0, 3'd1, 32'd0);
    reset_in_busy();
    do_access(OP_MRC, 4'd2, 4'd0, 3'd0, 3'd0, 32'd0);

    for (int t = 0; t < 150; t++) begin
      r  = int'($urandom_range(0, 9));
      op = (r == 0) ? OP_CDP : (r == 1) ? OP_LDC : (r < 6) ? OP_MCR : OP_MRC;
      r  = int'($urandom_range(0, 7));
      crn = (r == 0) ? 4'($urandom_range(0, 15)) : (r == 1) ? 4'hF : 4'($urandom_range(0, 3));
      crm = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      o1  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      o2  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      do_access(op, crn, crm, o1, o2, $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    do_access(OP_MCR, 4'hF, 4'd0, 3'd0, 3'd0, 32'hFFFFFFF0);
    repeat (25) @(negedge clk);
    do_access(OP_MRC, 4'hF, 4'd0, 3'd0, 3'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp15_sysctrl_unit.md
Name: cp15_sysctrl_unit

Overview:
- Parametrised system-control coprocessor slave for the arm7tdmi core. Successor to the fixed CP15 stub: configurable coprocessor number, register count, control write mask and access latency.
- Sits beside the core's execute stage and answers MRC/MCR over a request/ready handshake. Flags illegal accesses so the core can raise the undefined-instruction exception.
- Exports the control register to the rest of the design.

Parameters:
- CP_NUM, 15, coprocessor number this unit answers to.
- ID_VALUE, 32'h41007700, read-only value of c0.
- NUM_CRN, 4, number of implemented registers c0..c(NUM_CRN-1). Legal range is 2..15.
- BUSY_CYCLES, 2, wait cycles inserted before a legal access completes. Legal range is 0..15.
- CTRL_WMASK, 32'h0000000F, writable bits of c1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- cp_req  in  1  request; held with all fields stable until cp_ready
- cp_op  in  2  operation: 00 CDP, 01 LDC/STC, 10 MCR, 11 MRC
- cp_num  in  4  coprocessor number
- cp_crn  in  4  CRn
- cp_crm  in  4  CRm
- cp_opcode1  in  3  opcode1
- cp_opcode2  in  3  opcode2
- cp_wdata  in  32  MCR write data
- cp_present  out  1  combinational: cp_num == CP_NUM
- cp_ready  out  1  one-cycle completion pulse
- cp_exception  out  1  qualifies cp_ready: access illegal
- cp_rdata  out  32  MRC result; valid while cp_ready=1
- cp_busy  out  1  high in BUSY state
- ctrl_out  out  32  current c1 value

Behaviour:
- Reset values (rst_n sampled low on clk rise): state IDLE, cp_ready 0, cp_exception 0, cp_busy 0, cp_rdata 0, c1 0, c2..c(NUM_CRN-1) 0, ctrl_out 0.
- Reset mid-operation: any state returns to IDLE. No cp_ready is issued and no register write occurs.
- States are IDLE, BUSY and RESP.
- IDLE with cp_req=1 and cp_num != CP_NUM:
  - Request is ignored: no state change, no cp_ready.
  - The core resolves the access via cp_present=0.
- IDLE with cp_req=1 and cp_num == CP_NUM: the request is latched and classified.
- Legal access, all of the following:
  - cp_op is MRC or MCR;
  - cp_opcode1=0, cp_crm=0, cp_opcode2=0;
  - cp_crn < NUM_CRN.
- Illegal access:
  - Goes to RESP next cycle; cp_ready=1 and cp_exception=1 for that one cycle.
  - No register changes; cp_rdata holds its previous value.
  - Latency is 1 cycle regardless of BUSY_CYCLES.
- Legal access:
  - With BUSY_CYCLES>0: go to BUSY with the counter loaded to BUSY_CYCLES, decrementing each cycle; go to RESP when it reaches 1.
  - With BUSY_CYCLES=0: go straight to RESP.
  - cp_ready rises BUSY_CYCLES+1 cycles after the accepting edge, with cp_exception=0.
- MRC: cp_rdata is registered on the edge entering RESP.
  - c0 returns ID_VALUE, c1 returns the control register, c2+ return the scratch registers.
- MCR:
  - The write commits on the edge leaving RESP.
  - c0: write ignored, no exception.
  - c1: new value = (old & ~CTRL_WMASK) | (cp_wdata & CTRL_WMASK).
  - c2+: full 32-bit write.
  - cp_rdata is unchanged.
- ctrl_out is driven from the c1 register and updates the cycle after the MCR's cp_ready.
- RESP always returns to IDLE. The core drops cp_req in the cycle after cp_ready; a cp_req still high in IDLE is treated as a new request.
- cp_busy is 1 only in BUSY.

Optional Feature:
- Macro: CP15_CYCLE_COUNTER_EN.
- Defined: c15 is a 32-bit free-running cycle counter.
  - Resets to 0 and increments every clk, wrapping 0xFFFFFFFF to 0.
  - MRC c15 returns the counter value at the edge entering RESP.
  - MCR c15 loads cp_wdata on the edge leaving RESP; counting continues from that value.
  - The legality check treats c15 as implemented.
- Undefined: c15 is illegal unless NUM_CRN covers it, which it cannot. Any access returns cp_exception.

Test Plan:
- MRC c0 with defaults, req held: cp_ready exactly 3 cycles after acceptance, cp_rdata=0x41007700, cp_exception=0, cp_busy high for 2 cycles.
- MCR c1 with wdata 0xFFFFFFFF, then MRC c1 → ctrl_out=0x0000000F and read 0x0000000F. MCR c0 with 0x12345678, then MRC c0 → still 0x41007700.
- cp_num=14, MRC, req held 20 cycles → cp_present=0, cp_ready never asserted. CDP on p15 → ready and exception one cycle after acceptance; c1 unchanged.
- NUM_CRN=4, MRC c7; then MRC c1 with opcode2=1 → both give a 1-cycle exception response; cp_rdata keeps its prior value.
- MCR c2 with 0xA5A5A5A5, rst_n low for 1 cycle while in BUSY → no cp_ready, state IDLE, MRC c2 reads 0.
- With CP15_CYCLE_COUNTER_EN, MCR c15 with 0xFFFFFFF0, then MRC c15 → value wrapped past 0 and equals the cycle count elapsed since the load, modulo 2^32. Without the macro → exception.
